alu_op_sequencer: RTL and testbench

- Issuing side of the ALU operand/control interface.
- Accepts one operation request over a valid/ready handshake and drives reg1, reg2, control and inc_pc into the ALU.
- Waits for the ALU's negedge-registered result to settle, then captures z_Output1/z_Output2 into LO/HI result registers.
- Returns the result over a valid/ready response handshake.
- Sits between the datapath control unit and the ALU. It also screens illegal opcodes and divide-by-zero so the ALU is never issued an undefined operation.

---
 rtl/alu_op_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one screened operation to the ALU and returns its LO/HI result
// over valid/ready request and response handshakes.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int OP_W          = 4
) (
  input  logic            Clk,
  input  logic            Clear,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic            req_inc_pc,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  output logic [31:0]     alu_reg1,
  output logic [31:0]     alu_reg2,
  output logic [OP_W-1:0] alu_control,
  output logic            alu_inc_pc,
  input  logic [31:0]     alu_z1,
  input  logic [31:0]     alu_z2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_lo,
  output logic [31:0]     rsp_hi,
  output logic            rsp_err
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [OP_W-1:0]  CTRL_IDLE = {OP_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_a, r_b, r_lo, r_hi, r_reg1, r_reg2;
  logic [OP_W-1:0]  r_op, r_ctrl;
  logic             r_inc, r_alu_inc, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_illegal, w_div0, w_muldiv;

  assign w_illegal = !req_inc_pc && (req_op >= OP_W'(12));
  assign w_div0    = !req_inc_pc && (req_op == '0) && (req_b == '0);
  assign w_muldiv  = !r_inc && ((r_op == OP_W'(0)) || (r_op == OP_W'(1)));

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_lo      = r_lo;
  assign rsp_hi      = r_hi;
  assign rsp_err     = r_err;
  assign alu_reg1    = r_reg1;
  assign alu_reg2    = r_reg2;
  assign alu_control = r_ctrl;
  assign alu_inc_pc  = r_alu_inc;

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_next = (w_illegal || w_div0) ? S_RESP : S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (r_cnt == '0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_inc     <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_err     <= 1'b0;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_ctrl    <= CTRL_IDLE;
      r_alu_inc <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_a   <= req_a;
            r_b   <= req_b;
            r_op  <= req_op;
            r_inc <= req_inc_pc;
            if (w_illegal) begin
              r_err <= 1'b1;
            end else if (w_div0) begin
              r_err <= 1'b1;
              r_lo  <= 32'hFFFF_FFFF;
              r_hi  <= req_a;
            end
          end
        end
        S_ISSUE: begin
          // Increment forces control to idle so the multiply decode cannot win over inc_pc.
          r_reg1    <= r_a;
          r_reg2    <= r_b;
          r_ctrl    <= r_inc ? CTRL_IDLE : r_op;
          r_alu_inc <= r_inc;
          r_cnt     <= CNT_LOAD;
        end
        S_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_CAPTURE: begin
          r_lo      <= alu_z1;
          if (w_muldiv) r_hi <= alu_z2;
          r_err     <= 1'b0;
          r_ctrl    <= CTRL_IDLE;
          r_alu_inc <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed and random checks of alu_op_sequencer against a behavioural ALU
// and a request-level result model.
module tb_alu_op_sequencer;

  logic        Clk, Clear;
  logic        req_valid, req_ready, req_inc_pc;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_reg1, alu_reg2, alu_z1, alu_z2;
  logic [3:0]  alu_control;
  logic        alu_inc_pc;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_lo, rsp_hi;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_lo = 0;
  logic [31:0] m_hi = 0;

  alu_op_sequencer dut (
    .Clk(Clk), .Clear(Clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inc_pc(req_inc_pc), .req_a(req_a), .req_b(req_b),
    .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_control(alu_control),
    .alu_inc_pc(alu_inc_pc), .alu_z1(alu_z1), .alu_z2(alu_z2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Returns {z2, z1}; non-mul/div ops put junk on z2 so a wrongly captured HI is visible.
  function automatic logic [63:0] alu_fn(input logic [3:0] ctrl, input logic inc,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, d;
    logic [31:0] z1;
    logic [4:0]  s;
    s = b[4:0];
    d = {a, a};
    z1 = 32'h0;
    if (inc) z1 = b + 32'd1;
    else begin
      case (ctrl)
        4'd0: return (b != 0) ? {a % b, a / b} : 64'h0;
        4'd1: begin p = {32'h0, a} * {32'h0, b}; return p; end
        4'd2: z1 = a + b;
        4'd3: z1 = a - b;
        4'd4: z1 = a << s;
        4'd5: z1 = a >> s;
        4'd6: begin p = d >> s; z1 = p[31:0]; end
        4'd7: begin p = d << s; z1 = p[63:32]; end
        4'd8: z1 = a | b;
        4'd9: z1 = -a;
        4'd10: z1 = a & b;
        4'd11: z1 = ~a;
        default: z1 = 32'h0;
      endcase
    end
    return {z1 ^ 32'hA5A5_0000, z1};
  endfunction

  always @(negedge Clk or negedge Clear) begin
    if (!Clear) {alu_z2, alu_z1} <= 64'h0;
    else        {alu_z2, alu_z1} <= alu_fn(alu_control, alu_inc_pc, alu_reg1, alu_reg2);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic [3:0] op, input logic inc, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    logic [63:0] r;
    logic        e_err;
    logic [31:0] e_lo, e_hi;
    int          e_k, k;
    e_lo = m_lo;
    e_hi = m_hi;
    e_err = 1'b0;
    if (!inc && op >= 4'd12) e_err = 1'b1;
    else if (!inc && op == 4'd0 && b == 0) begin
      e_err = 1'b1; e_lo = 32'hFFFF_FFFF; e_hi = a;
    end else begin
      r = alu_fn(op, inc, a, b);
      e_lo = r[31:0];
      if (!inc && op <= 4'd1) e_hi = r[63:32];
    end
    e_k = e_err ? 0 : 4;

    chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_inc_pc = inc; req_a = a; req_b = b; rsp_ready = 1'b0;
    @(negedge Clk);
    req_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 12) begin
      if (!e_err && k >= 1 && k <= 3) begin
        chk("alu_control", {28'h0, alu_control}, inc ? 32'd15 : {28'h0, op});
        chk("alu_inc_pc", {31'h0, alu_inc_pc}, {31'h0, inc});
        if (k == 1) begin
          chk("alu_reg1", alu_reg1, a);
          chk("alu_reg2", alu_reg2, b);
        end
      end else begin
        chk("alu_control_idle", {28'h0, alu_control}, 32'd15);
      end
      chk("req_ready_busy", {31'h0, req_ready}, 32'd0);
      @(negedge Clk);
      k++;
    end
    chk("latency", 32'(k), 32'(e_k));
    chk("rsp_lo", rsp_lo, e_lo);
    chk("rsp_hi", rsp_hi, e_hi);
    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
    chk("alu_control_after", {28'h0, alu_control}, 32'd15);
    repeat (hold) begin
      @(negedge Clk);
      chk("bp_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'h0, req_ready}, 32'd0);
      chk("bp_lo", rsp_lo, e_lo);
      chk("bp_hi", rsp_hi, e_hi);
      chk("bp_err", {31'h0, rsp_err}, {31'h0, e_err});
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'h0, rsp_valid}, 32'd0);
    chk("req_ready_back", {31'h0, req_ready}, 32'd1);
    m_lo = e_lo;
    m_hi = e_hi;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'h0, rsp_valid}, 32'd0);
    chk({tag, "_err"}, {31'h0, rsp_err}, 32'd0);
    chk({tag, "_lo"}, rsp_lo, 32'd0);
    chk({tag, "_hi"}, rsp_hi, 32'd0);
    chk({tag, "_reg1"}, alu_reg1, 32'd0);
    chk({tag, "_reg2"}, alu_reg2, 32'd0);
    chk({tag, "_ctrl"}, {28'h0, alu_control}, 32'd15);
    chk({tag, "_inc"}, {31'h0, alu_inc_pc}, 32'd0);
  endtask

  initial begin
    Clear = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_inc_pc = 1'b0;
    req_a = 0; req_b = 0; rsp_ready = 1'b0;
    repeat (2) @(negedge Clk);
    chk_reset_state("reset");
    Clear = 1'b1;
    @(negedge Clk);
    chk("reset_req_ready", {31'h0, req_ready}, 32'd1);

    run_req(4'd2, 1'b0, 32'd5, 32'd7, 0);
    run_req(4'd1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0);
    run_req(4'd0, 1'b0, 32'd100, 32'd7, 0);
    run_req(4'd0, 1'b0, 32'd100, 32'd0, 0);
    run_req(4'd1, 1'b1, 32'd9, 32'h3C, 0);
    run_req(4'd3, 1'b0, 32'd50, 32'd8, 5);
    run_req(4'd13, 1'b0, 32'd1, 32'd2, 1);

    // Abort in WAIT: reset values must appear before the next clock edge.
    req_valid = 1'b1; req_op = 4'd2; req_inc_pc = 1'b0; req_a = 32'd3; req_b = 32'd4;
    @(negedge Clk);
    req_valid = 1'b0;
    @(negedge Clk);
    #2 Clear = 1'b0;
    #1 chk_reset_state("abort");
    chk("abort_req_ready", {31'h0, req_ready}, 32'd1);
    m_lo = 0; m_hi = 0;
    @(negedge Clk);
    Clear = 1'b1;
    repeat (8) begin
      @(negedge Clk);
      chk("abort_no_rsp", {31'h0, rsp_valid}, 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic        inc;
      logic [31:0] a, b;
      op  = 4'($urandom_range(0, 15));
      inc = ($urandom_range(0, 5) == 0);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_req(op, inc, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
